// File: rtl/slot_allocator.sv
// Slot allocator: zero-latency grant of a free slot (lowest or highest first),
// with per-slot data storage, multi-slot release, occupancy count and sticky error.

`ifndef Disable
`define Disable 1'b0
`endif
`ifndef Enable
`define Enable 1'b1
`endif

module slot_allocator #(
    parameter int unsigned DATA  = 8,
    parameter int unsigned ENTRY = 8,
    parameter bit          MSB   = `Disable
) (
    input  logic                        clk,
    input  logic                        reset_,
    input  logic                        req,
    input  logic [DATA-1:0]             wdata,
    output logic                        ack,
    output logic [$clog2(ENTRY)-1:0]    idx,
    output logic [ENTRY-1:0]            pos,
    input  logic [ENTRY-1:0]            rel,
    output logic [ENTRY-1:0]            busy,
    output logic [ENTRY-1:0][DATA-1:0]  data,
    output logic [$clog2(ENTRY+1)-1:0]  count,
    output logic                        full,
    output logic                        empty,
    output logic                        err
);

    localparam int unsigned IDX = $clog2(ENTRY);
    localparam int unsigned CNT = $clog2(ENTRY + 1);

    logic [ENTRY-1:0]           r_busy;
    logic [ENTRY-1:0][DATA-1:0] r_data;
    logic [CNT-1:0]             r_count;
    logic                       r_err;

    logic [IDX-1:0]   w_free_idx;
    logic             w_full;
    logic             w_ack;
    logic [IDX-1:0]   w_idx;
    logic [ENTRY-1:0] w_pos;
    logic [ENTRY-1:0] w_rel_valid;
    logic [CNT-1:0]   w_rel_cnt;
    logic             w_rel_bad;

    assign w_full = (r_count == CNT'(ENTRY));

    // Priority search over free slots; only the registered busy is used, so a
    // release never frees a slot for the same cycle.
    always_comb begin
        w_free_idx = '0;
        if (MSB) begin
            for (int i = 0; i < ENTRY; i++) begin
                if (!r_busy[i]) w_free_idx = IDX'(i);
            end
        end else begin
            for (int i = ENTRY - 1; i >= 0; i--) begin
                if (!r_busy[i]) w_free_idx = IDX'(i);
            end
        end
    end

    // Grant outputs are forced to zero whenever no grant is made.
    always_comb begin
        w_ack = req && !w_full;
        w_idx = '0;
        w_pos = '0;
        if (w_ack) begin
            w_idx = w_free_idx;
            w_pos = ENTRY'(1) << w_free_idx;
        end
    end

    // Only releases of occupied slots count; releases of free slots flag an error.
    always_comb begin
        w_rel_valid = rel & r_busy;
        w_rel_bad   = |(rel & ~r_busy);
        w_rel_cnt   = '0;
        for (int i = 0; i < ENTRY; i++) begin
            w_rel_cnt = w_rel_cnt + CNT'(w_rel_valid[i]);
        end
    end

    // Occupancy, count and sticky error; grant and release apply on the same edge.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_busy  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_busy  <= (r_busy & ~w_rel_valid) | w_pos;
            r_count <= r_count + CNT'(w_ack) - w_rel_cnt;
            if (w_rel_bad) r_err <= 1'b1;
        end
    end

    // Slot contents load on grant and are kept across release.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_data <= '0;
        end else begin
            for (int i = 0; i < ENTRY; i++) begin
                if (w_pos[i]) r_data[i] <= wdata;
            end
        end
    end

    assign ack   = w_ack;
    assign idx   = w_idx;
    assign pos   = w_pos;
    assign busy  = r_busy;
    assign data  = r_data;
    assign count = r_count;
    assign full  = w_full;
    assign empty = (r_count == '0);
    assign err   = r_err;

endmodule

// File: tb/tb_slot_allocator.sv
// Directed bench for slot_allocator: ENTRY=4, DATA=8, one instance per priority mode.

`ifndef Disable
`define Disable 1'b0
`endif
`ifndef Enable
`define Enable 1'b1
`endif

module tb_slot_allocator;

    logic            clk = 1'b0;
    logic            reset_ = 1'b0;

    // Lowest-first instance
    logic            req_d = 1'b0;
    logic [7:0]      wdata_d = '0;
    logic [3:0]      rel_d = '0;
    logic            ack_d;
    logic [1:0]      idx_d;
    logic [3:0]      pos_d;
    logic [3:0]      busy_d;
    logic [3:0][7:0] data_d;
    logic [2:0]      count_d;
    logic            full_d, empty_d, err_d;

    // Highest-first instance
    logic            req_m = 1'b0;
    logic [7:0]      wdata_m = '0;
    logic [3:0]      rel_m = '0;
    logic            ack_m;
    logic [1:0]      idx_m;
    logic [3:0]      pos_m;
    logic [3:0]      busy_m;
    logic [3:0][7:0] data_m;
    logic [2:0]      count_m;
    logic            full_m, empty_m, err_m;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    slot_allocator #(.DATA(8), .ENTRY(4), .MSB(`Disable)) u_lsb (
        .clk(clk), .reset_(reset_), .req(req_d), .wdata(wdata_d), .ack(ack_d), .idx(idx_d),
        .pos(pos_d), .rel(rel_d), .busy(busy_d), .data(data_d), .count(count_d),
        .full(full_d), .empty(empty_d), .err(err_d)
    );

    slot_allocator #(.DATA(8), .ENTRY(4), .MSB(`Enable)) u_msb (
        .clk(clk), .reset_(reset_), .req(req_m), .wdata(wdata_m), .ack(ack_m), .idx(idx_m),
        .pos(pos_m), .rel(rel_m), .busy(busy_m), .data(data_m), .count(count_m),
        .full(full_m), .empty(empty_m), .err(err_m)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_d = 0; rel_d = '0; req_m = 0; rel_m = '0;
        @(negedge clk);
        reset_ = 1'b0;
        #2;
        reset_ = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset_ = 1'b0;
        req_d = 1'b1; req_m = 1'b1;
        #2;
        n_cmp++; if (busy_d !== 4'b0000) begin n_bad++; $display("FAIL rst_busy: got %b want 0000", busy_d); end
        n_cmp++; if (count_d !== 3'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", count_d); end
        n_cmp++; if (err_d !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err_d); end
        n_cmp++; if (full_d !== 1'b0 || empty_d !== 1'b1) begin n_bad++; $display("FAIL rst_flags: got full=%b empty=%b want 0/1", full_d, empty_d); end
        n_cmp++; if (data_d !== 32'h0) begin n_bad++; $display("FAIL rst_data: got %h want 0", data_d); end
        n_cmp++; if (ack_d !== 1'b1 || idx_d !== 2'd0 || pos_d !== 4'b0001) begin n_bad++; $display("FAIL rst_grant_lsb: got ack=%b idx=%0d pos=%b want 1/0/0001", ack_d, idx_d, pos_d); end
        n_cmp++; if (ack_m !== 1'b1 || idx_m !== 2'd3 || pos_m !== 4'b1000) begin n_bad++; $display("FAIL rst_grant_msb: got ack=%b idx=%0d pos=%b want 1/3/1000", ack_m, idx_m, pos_m); end
        req_d = 1'b0; req_m = 1'b0;
        #1;
        n_cmp++; if (ack_d !== 1'b0 || idx_d !== 2'd0 || pos_d !== 4'b0000) begin n_bad++; $display("FAIL rst_noreq: got ack=%b idx=%0d pos=%b want 0/0/0000", ack_d, idx_d, pos_d); end
        do_reset();
    endtask

    task automatic test_fill();
        logic [7:0] wv;
        logic [3:0] pv;
        for (int k = 0; k < 4; k++) begin
            wv = 8'h11 * 8'(k + 1);
            pv = 4'b0001 << k;
            req_d = 1'b1; wdata_d = wv;
            #1;
            n_cmp++; if (ack_d !== 1'b1 || idx_d !== 2'(k) || pos_d !== pv) begin n_bad++; $display("FAIL fill_grant%0d: got ack=%b idx=%0d pos=%b want 1/%0d/%b", k, ack_d, idx_d, pos_d, k, pv); end
            tick();
        end
        n_cmp++; if (busy_d !== 4'b1111 || full_d !== 1'b1 || count_d !== 3'd4 || empty_d !== 1'b0) begin n_bad++; $display("FAIL fill_state: got busy=%b full=%b count=%0d empty=%b want 1111/1/4/0", busy_d, full_d, count_d, empty_d); end
        n_cmp++; if (data_d[2] !== 8'h33 || data_d[0] !== 8'h11 || data_d[3] !== 8'h44) begin n_bad++; $display("FAIL fill_data: got %h want 44332211", data_d); end
        wdata_d = 8'h55;
        #1;
        n_cmp++; if (ack_d !== 1'b0 || idx_d !== 2'd0 || pos_d !== 4'b0000) begin n_bad++; $display("FAIL fill_fifth: got ack=%b idx=%0d pos=%b want 0/0/0000", ack_d, idx_d, pos_d); end
        tick();
        n_cmp++; if (busy_d !== 4'b1111 || count_d !== 3'd4 || err_d !== 1'b0 || data_d !== 32'h44332211) begin n_bad++; $display("FAIL fill_fifth_state: got busy=%b count=%0d err=%b data=%h", busy_d, count_d, err_d, data_d); end
        req_d = 1'b0;
    endtask

    // Starts from the full state left by test_fill
    task automatic test_release_full();
        req_d = 1'b1; rel_d = 4'b0101; wdata_d = 8'hAA;
        #1;
        n_cmp++; if (ack_d !== 1'b0) begin n_bad++; $display("FAIL relfull_ack: got %b want 0", ack_d); end
        tick();
        rel_d = '0;
        n_cmp++; if (busy_d !== 4'b1010 || count_d !== 3'd2 || err_d !== 1'b0 || full_d !== 1'b0) begin n_bad++; $display("FAIL relfull_state: got busy=%b count=%0d err=%b full=%b want 1010/2/0/0", busy_d, count_d, err_d, full_d); end
        n_cmp++; if (data_d[2] !== 8'h33) begin n_bad++; $display("FAIL relfull_retain: got %h want 33", data_d[2]); end
        wdata_d = 8'hBB;
        #1;
        n_cmp++; if (ack_d !== 1'b1 || idx_d !== 2'd0) begin n_bad++; $display("FAIL relfull_next: got ack=%b idx=%0d want 1/0", ack_d, idx_d); end
        tick();
        req_d = 1'b0;
        n_cmp++; if (busy_d !== 4'b1011 || data_d[0] !== 8'hBB || count_d !== 3'd3) begin n_bad++; $display("FAIL relfull_load: got busy=%b data0=%h count=%0d want 1011/bb/3", busy_d, data_d[0], count_d); end
    endtask

    task automatic test_concurrent();
        do_reset();
        req_d = 1'b1;
        tick(); tick();
        n_cmp++; if (busy_d !== 4'b0011) begin n_bad++; $display("FAIL conc_setup: got %b want 0011", busy_d); end
        rel_d = 4'b0001; wdata_d = 8'hC2;
        #1;
        n_cmp++; if (ack_d !== 1'b1 || idx_d !== 2'd2 || pos_d !== 4'b0100) begin n_bad++; $display("FAIL conc_grant: got ack=%b idx=%0d pos=%b want 1/2/0100", ack_d, idx_d, pos_d); end
        tick();
        req_d = 1'b0; rel_d = '0;
        n_cmp++; if (busy_d !== 4'b0110 || count_d !== 3'd2 || err_d !== 1'b0 || data_d[2] !== 8'hC2) begin n_bad++; $display("FAIL conc_state: got busy=%b count=%0d err=%b data2=%h want 0110/2/0/c2", busy_d, count_d, err_d, data_d[2]); end
    endtask

    task automatic test_error();
        do_reset();
        req_d = 1'b1;
        tick();
        req_d = 1'b0; rel_d = 4'b0010;
        tick();
        rel_d = '0;
        n_cmp++; if (busy_d !== 4'b0001 || count_d !== 3'd1 || err_d !== 1'b1) begin n_bad++; $display("FAIL err_set: got busy=%b count=%0d err=%b want 0001/1/1", busy_d, count_d, err_d); end
        req_d = 1'b1; rel_d = 4'b0001;
        #1;
        n_cmp++; if (ack_d !== 1'b1 || idx_d !== 2'd1) begin n_bad++; $display("FAIL err_grant: got ack=%b idx=%0d want 1/1", ack_d, idx_d); end
        tick();
        req_d = 1'b0; rel_d = '0;
        tick();
        n_cmp++; if (busy_d !== 4'b0010 || count_d !== 3'd1 || err_d !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got busy=%b count=%0d err=%b want 0010/1/1", busy_d, count_d, err_d); end
    endtask

    task automatic test_priority_msb();
        do_reset();
        req_m = 1'b1; wdata_m = 8'h5A;
        #1;
        n_cmp++; if (ack_m !== 1'b1 || idx_m !== 2'd3 || pos_m !== 4'b1000) begin n_bad++; $display("FAIL msb_first: got ack=%b idx=%0d pos=%b want 1/3/1000", ack_m, idx_m, pos_m); end
        tick();
        #1;
        n_cmp++; if (idx_m !== 2'd2 || pos_m !== 4'b0100) begin n_bad++; $display("FAIL msb_second: got idx=%0d pos=%b want 2/0100", idx_m, pos_m); end
        tick();
        req_m = 1'b0;
        n_cmp++; if (busy_m !== 4'b1100 || count_m !== 3'd2 || data_m[3] !== 8'h5A || busy_d !== 4'b0000) begin n_bad++; $display("FAIL msb_state: got busy_m=%b count_m=%0d data3=%h busy_d=%b", busy_m, count_m, data_m[3], busy_d); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_d = 1'b1;
        tick(); tick(); tick(); tick();
        req_d = 1'b0; rel_d = 4'b0100;
        tick();
        n_cmp++; if (busy_d !== 4'b1011 || count_d !== 3'd3) begin n_bad++; $display("FAIL mid_setup: got busy=%b count=%0d want 1011/3", busy_d, count_d); end
        tick();
        rel_d = '0;
        n_cmp++; if (err_d !== 1'b1) begin n_bad++; $display("FAIL mid_err_pre: got %b want 1", err_d); end
        #2;
        reset_ = 1'b0;
        #1;
        n_cmp++; if (busy_d !== 4'b0000 || count_d !== 3'd0 || err_d !== 1'b0 || data_d !== 32'h0) begin n_bad++; $display("FAIL mid_async: got busy=%b count=%0d err=%b data=%h want all 0", busy_d, count_d, err_d, data_d); end
        n_cmp++; if (full_d !== 1'b0 || empty_d !== 1'b1) begin n_bad++; $display("FAIL mid_flags: got full=%b empty=%b want 0/1", full_d, empty_d); end
        #1;
        reset_ = 1'b1;
        req_d = 1'b1;
        #1;
        n_cmp++; if (ack_d !== 1'b1 || idx_d !== 2'd0) begin n_bad++; $display("FAIL mid_first: got ack=%b idx=%0d want 1/0", ack_d, idx_d); end
        tick();
        req_d = 1'b0;
        n_cmp++; if (busy_d !== 4'b0001 || count_d !== 3'd1) begin n_bad++; $display("FAIL mid_after: got busy=%b count=%0d want 0001/1", busy_d, count_d); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_release_full();
        test_concurrent();
        test_error();
        test_priority_msb();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
